// File: rtl/fwd_select_ctrl_pkg.sv
// fwd_select_ctrl_pkg: shared operand-mux select encodings and default tag width
package fwd_select_ctrl_pkg;
   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam logic [1:0] SEL_REGFILE = 2'b00;
   localparam logic [1:0] SEL_EXMEM   = 2'b01;
   localparam logic [1:0] SEL_MEMWB   = 2'b10;
endpackage

// File: rtl/fwd_select_ctrl_if.sv
// fwd_select_ctrl_if: decode-side request and forwarding-select response bundle
interface fwd_select_ctrl_if #(parameter int REG_ADDR_WIDTH = fwd_select_ctrl_pkg::DEF_REG_ADDR_WIDTH);
   logic stall;
   logic flush;
   logic issue_valid;
   logic issue_writes;
   logic issue_is_load;
   logic [REG_ADDR_WIDTH-1:0] issue_dest;
   logic [REG_ADDR_WIDTH-1:0] src_a;
   logic [REG_ADDR_WIDTH-1:0] src_b;
   logic [1:0] select_a;
   logic [1:0] select_b;
   logic load_use_stall;
   modport master(output stall, flush, issue_valid, issue_writes, issue_is_load, issue_dest, src_a, src_b,
                  input select_a, select_b, load_use_stall);
   modport slave(input stall, flush, issue_valid, issue_writes, issue_is_load, issue_dest, src_a, src_b,
                 output select_a, select_b, load_use_stall);
endinterface

// File: rtl/fwd_select_ctrl_fwd_compare.sv
// fwd_compare: picks the newest in-flight producer of one source tag
module fwd_compare
   import fwd_select_ctrl_pkg::*;
#(
   parameter int W           = DEF_REG_ADDR_WIDTH,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input  logic [W-1:0] src,
   input  logic         s1_valid,
   input  logic         s1_writes,
   input  logic         s1_is_load,
   input  logic [W-1:0] s1_dest,
   input  logic         s2_valid,
   input  logic         s2_writes,
   input  logic [W-1:0] s2_dest,
   output logic [1:0]   sel,
   output logic         load_match
);
   logic live, m1, m2;
   // EX producer beats MEM producer; tag 0 never forwards when hard-wired
   always_comb begin
      live = !(ZERO_REG_EN && src == '0);
      m1 = live && s1_valid && s1_writes && s1_dest == src;
      m2 = live && s2_valid && s2_writes && s2_dest == src;
      sel = m1 ? SEL_EXMEM : m2 ? SEL_MEMWB : SEL_REGFILE;
      load_match = m1 && s1_is_load;
   end
endmodule

// File: rtl/fwd_select_ctrl.sv
// fwd_select_ctrl: tracks EX/MEM destinations, registers bypass selects, inserts load-use bubbles
module fwd_select_ctrl
   import fwd_select_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter bit ZERO_REG_EN    = 1'b1
) (
   input logic clk,
   input logic rst,
   fwd_select_ctrl_if.slave bus
);
   logic s1_valid, s1_writes, s1_is_load, s2_valid, s2_writes;
   logic [REG_ADDR_WIDTH-1:0] s1_dest, s2_dest;
   logic [1:0] sel_a, sel_b;
   logic lm_a, lm_b;

   fwd_compare #(.W(REG_ADDR_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)) cmp_a (
      .src(bus.src_a), .s1_valid(s1_valid), .s1_writes(s1_writes), .s1_is_load(s1_is_load),
      .s1_dest(s1_dest), .s2_valid(s2_valid), .s2_writes(s2_writes), .s2_dest(s2_dest),
      .sel(sel_a), .load_match(lm_a));

   fwd_compare #(.W(REG_ADDR_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)) cmp_b (
      .src(bus.src_b), .s1_valid(s1_valid), .s1_writes(s1_writes), .s1_is_load(s1_is_load),
      .s1_dest(s1_dest), .s2_valid(s2_valid), .s2_writes(s2_writes), .s2_dest(s2_dest),
      .sel(sel_b), .load_match(lm_b));

   assign bus.load_use_stall = bus.issue_valid && (lm_a || lm_b);

   // advance EX/MEM tag records; flush > freeze > bubble > normal issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_writes    <= 1'b0;
         s1_is_load   <= 1'b0;
         s1_dest      <= '0;
         s2_valid     <= 1'b0;
         s2_writes    <= 1'b0;
         s2_dest      <= '0;
         bus.select_a <= SEL_REGFILE;
         bus.select_b <= SEL_REGFILE;
      end else if (bus.flush) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         bus.select_a <= SEL_REGFILE;
         bus.select_b <= SEL_REGFILE;
      end else if (!bus.stall) begin
         s2_valid     <= s1_valid;
         s2_writes    <= s1_writes;
         s2_dest      <= s1_dest;
         s1_valid     <= bus.issue_valid && !bus.load_use_stall;
         s1_writes    <= bus.issue_writes;
         s1_is_load   <= bus.issue_is_load;
         s1_dest      <= bus.issue_dest;
         bus.select_a <= (bus.issue_valid && !bus.load_use_stall) ? sel_a : SEL_REGFILE;
         bus.select_b <= (bus.issue_valid && !bus.load_use_stall) ? sel_b : SEL_REGFILE;
      end
   end
endmodule

// File: doc/fwd_select_ctrl.md
# fwd_select_ctrl

Forwarding-select controller for the integer pipeline's operand bypass path. It tracks the destination tags of the two instructions ahead of decode, in EX and MEM. It produces registered 2-bit selects that drive the two 32-bit 3:1 operand muxes at the EX input:

- In0 = register-file value
- In1 = EX/MEM result
- In2 = MEM/WB result

It also detects load-use hazards, requests a one-cycle decode stall, and inserts the bubble itself.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, width of register tags.
- ZERO_REG_EN, 1, when 1, tag 0 is hard-wired zero and is never forwarded.

Ports:
- Clock  input  1  rising-edge clock; one clock domain.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Stall  input  1  external pipeline freeze (memory wait); holds all state.
- Flush  input  1  branch/exception flush of EX and MEM.
- IssueValid  input  1  decode holds a valid instruction this cycle.
- IssueWrites  input  1  decode instruction writes a register.
- IssueIsLoad  input  1  decode instruction is a load.
- IssueDest  input  REG_ADDR_WIDTH  decode destination tag.
- SrcA, SrcB  input  REG_ADDR_WIDTH  decode source tags.
- SelectA, SelectB  output  2  registered mux selects for operands A and B.
- LoadUseStall  output  1  combinational request to hold decode/fetch.

## Operation
- Internal state:
  - Stage1 = {valid, writes, isload, dest} for the instruction in EX.
  - Stage2 = {valid, writes, dest} for the instruction in MEM.
- A stage "matches" source S when all of the following hold: valid=1, writes=1, dest==S, and not (ZERO_REG_EN and S==0).
- Select computation per source (A, B independently), in priority order:
  1. Stage1 match → 01 (EX/MEM).
  2. Otherwise Stage2 match → 10 (MEM/WB).
  3. Otherwise → 00.
- Newest producer always wins.
- LoadUseStall = IssueValid & Stage1.isload & (Stage1 matches SrcA or SrcB).
- Per rising edge, the first matching rule applies:
  1. Flush=1: Stage1.valid ← 0, Stage2.valid ← 0, SelectA/B ← 00. Flush beats Stall and LoadUseStall.
  2. Stall=1: all state and SelectA/B hold. LoadUseStall output still reflects current compare.
  3. LoadUseStall=1: bubble inserted.
     - Stage2 ← Stage1.
     - Stage1.valid ← 0.
     - SelectA/B ← 00, since the bubble enters EX.
  4. Normal:
     - Stage2 ← Stage1.
     - Stage1 ← {IssueValid, IssueWrites, IssueIsLoad, IssueDest}.
     - SelectA/B ← computed selects, or 00 when IssueValid=0.
- Select value 11 is never driven.
- Reset values: SelectA=00, SelectB=00, LoadUseStall=0 (both stages invalid), Stage1/Stage2 cleared.

## Timing
- Select latency: 1 cycle. Selects computed from cycle-N decode tags appear at cycle N+1, aligned with that instruction's operands at the EX mux.
- LoadUseStall is same-cycle combinational from the inputs and the Stage1 registers.
- Load-use sequence: stall asserted for exactly 1 cycle (absent external Stall). On the following cycle the load is in Stage2, so the same decode instruction computes select 10.
- Reset asserted mid-operation: outputs reach reset values without waiting for a clock edge. The first edge after deassertion behaves as Normal.
- Back-to-back writers of the same tag: Stage1 wins over Stage2.

## Structure
- Shared package: constants SEL_REGFILE=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, and REG_ADDR_WIDTH default. The mux consumers use the same constants.
- One sub-module: fwd_compare. Inputs are one source tag plus both stage records; outputs are the 2-bit select and a load-match bit. It is instantiated twice, for A and B.
- Stage registers and the edge-rule priority logic stay in the top module.

## Test plan
- Reset: assert Reset mid-stream with Stage1 dest=3 valid → SelectA/B=00 and LoadUseStall=0 immediately; after release, decode SrcA=3 → SelectA=00.
- EX forward: issue writer dest=7, then next cycle SrcA=7 → SelectA=01 one cycle later; SrcB=0 with a writer to 0 (ZERO_REG_EN=1) → SelectB=00.
- MEM forward and priority:
  - Issue writers dest=4, then dest=9, then SrcA=4, SrcB=9 → SelectA=10, SelectB=01.
  - Two consecutive writers to 4, then SrcA=4 → SelectA=01.
- Load-use: issue load dest=5, then SrcB=5 → LoadUseStall=1 for 1 cycle, SelectA/B=00 on the next edge, then SelectB=10 on the edge after.
- Flush/Stall: Stall=1 for 3 cycles holds SelectA=01 and stage state; Flush=1 together with Stall=1 → selects 00 and SrcA matching old tags → 00 next cycle.
